// File: rtl/ex_result_skid_if.sv
// Handshake bundle between the ALU stage, the EX result skid buffer and its consumer.
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface ex_result_skid_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  // A transfer happens on a rising edge where valid and ready are both high.
  // Once valid is raised, the payload stays stable until that transfer happens.
  // Ready may be high while valid is low.
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_neg;
  logic            alu_overflow;
  logic            alu_carry;
  logic [RAW-1:0]  in_rd;
  logic            in_regwrite;
  logic            in_branch;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_target;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RAW-1:0]  out_rd;
  logic            out_regwrite;
  logic            out_taken;
  logic [XLEN-1:0] out_target;

  modport slave (
    input  in_valid, alu_result, alu_zero, alu_neg, alu_overflow, alu_carry,
           in_rd, in_regwrite, in_branch, in_funct3, in_target, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_regwrite, out_taken, out_target
  );

  modport master (
    output in_valid, alu_result, alu_zero, alu_neg, alu_overflow, alu_carry,
           in_rd, in_regwrite, in_branch, in_funct3, in_target, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_regwrite, out_taken, out_target
  );
endinterface

// File: rtl/ex_result_skid.sv
// Registered EX->MEM/WB boundary: resolves branches from ALU flags and holds results
// in a 2-entry skid buffer (head + skid) so ready never chains combinationally.
module ex_result_skid #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  ex_result_skid_if.slave  bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t          state;
  logic            out_valid_q;
  logic            in_ready_q;

  logic [XLEN-1:0] h_result, s_result;
  logic [XLEN-1:0] h_target, s_target;
  logic [RAW-1:0]  h_rd, s_rd;
  logic            h_regwrite, s_regwrite;
  logic            h_taken, s_taken;

  logic            cap_taken;
  logic            cap_regwrite;
  logic            push;
  logic            pop;

  // Branch condition is resolved once at capture, so the stored entry carries only the outcome.
  always_comb begin
    cap_taken = 1'b0;
    if (bus.in_branch) begin
      case (bus.in_funct3)
        3'b000:  cap_taken = bus.alu_zero;
        3'b001:  cap_taken = ~bus.alu_zero;
        3'b100:  cap_taken = bus.alu_neg ^ bus.alu_overflow;
        3'b101:  cap_taken = ~(bus.alu_neg ^ bus.alu_overflow);
        3'b110:  cap_taken = ~bus.alu_carry;
        3'b111:  cap_taken = bus.alu_carry;
        default: cap_taken = 1'b0;
      endcase
    end
  end

  assign cap_regwrite = bus.in_regwrite & ~bus.in_branch;
  assign push         = bus.in_valid & in_ready_q;
  assign pop          = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      h_result    <= '0;
      h_target    <= '0;
      h_rd        <= '0;
      h_regwrite  <= 1'b0;
      h_taken     <= 1'b0;
      s_result    <= '0;
      s_target    <= '0;
      s_rd        <= '0;
      s_regwrite  <= 1'b0;
      s_taken     <= 1'b0;
    end else if (flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            h_result    <= bus.alu_result;
            h_target    <= bus.in_target;
            h_rd        <= bus.in_rd;
            h_regwrite  <= cap_regwrite;
            h_taken     <= cap_taken;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          // New entry goes straight to head when head leaves this cycle, else into skid.
          if (push && pop) begin
            h_result   <= bus.alu_result;
            h_target   <= bus.in_target;
            h_rd       <= bus.in_rd;
            h_regwrite <= cap_regwrite;
            h_taken    <= cap_taken;
          end else if (push) begin
            s_result   <= bus.alu_result;
            s_target   <= bus.in_target;
            s_rd       <= bus.in_rd;
            s_regwrite <= cap_regwrite;
            s_taken    <= cap_taken;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            h_result   <= s_result;
            h_target   <= s_target;
            h_rd       <= s_rd;
            h_regwrite <= s_regwrite;
            h_taken    <= s_taken;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = h_result;
  assign bus.out_rd       = h_rd;
  assign bus.out_regwrite = h_regwrite;
  assign bus.out_taken    = h_taken;
  assign bus.out_target   = h_target;
  assign dbg_state        = state;

endmodule

// File: tb/tb_ex_result_skid.sv
// Self-checking bench for ex_result_skid: directed scenarios plus a randomized
// run scored against a FIFO reference model of capacity two.
module tb_ex_result_skid;
  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int W    = XLEN + RAW + 1 + 1 + XLEN;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] dbg_state;

  ex_result_skid_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

  ex_result_skid #(.XLEN(XLEN), .RAW(RAW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] res, input logic [RAW-1:0] rd,
                       input logic rw, input logic br, input logic [2:0] f3,
                       input logic [XLEN-1:0] tgt, input logic z, input logic n,
                       input logic o, input logic c);
    bus.in_valid     = v;
    bus.alu_result   = res;
    bus.in_rd        = rd;
    bus.in_regwrite  = rw;
    bus.in_branch    = br;
    bus.in_funct3    = f3;
    bus.in_target    = tgt;
    bus.alu_zero     = z;
    bus.alu_neg      = n;
    bus.alu_overflow = o;
    bus.alu_carry    = c;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Branch outcome straight from the condition-code table.
  function automatic logic ref_taken(input logic br, input logic [2:0] f3, input logic z,
                                     input logic n, input logic o, input logic c);
    if (!br) return 1'b0;
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4) return n != o;
    if (f3 == 3'd5) return n == o;
    if (f3 == 3'd6) return !c;
    if (f3 == 3'd7) return c;
    return 1'b0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    tick();
    tick();
    checks += 3;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    if ({bus.out_result, bus.out_rd, bus.out_regwrite, bus.out_taken, bus.out_target} !== '0) begin
      failures++; $display("FAIL reset_payload got=%h/%h/%b/%b/%h exp=0", bus.out_result,
                           bus.out_rd, bus.out_regwrite, bus.out_taken, bus.out_target);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h5, 5'd3, 1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checks += 5;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid);
    end
    if (bus.out_result !== 32'h5) begin
      failures++; $display("FAIL basic_result got=%h exp=5", bus.out_result);
    end
    if (bus.out_rd !== 5'd3) begin
      failures++; $display("FAIL basic_rd got=%0d exp=3", bus.out_rd);
    end
    if (bus.out_taken !== 1'b0) begin
      failures++; $display("FAIL basic_taken got=%b exp=0", bus.out_taken);
    end
    if (bus.out_regwrite !== 1'b1) begin
      failures++; $display("FAIL basic_regwrite got=%b exp=1", bus.out_regwrite);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_after_a got=%b exp=1", bus.in_ready);
    end
    drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checks += 2;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_ready_full got=%b exp=0", bus.in_ready);
    end
    if (bus.out_result !== 32'h11) begin
      failures++; $display("FAIL bp_head_a got=%h exp=11", bus.out_result);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h11 || bus.out_rd !== 5'd1) begin
      failures++; $display("FAIL bp_hold got=%b/%h/%0d exp=1/11/1", bus.out_valid,
                           bus.out_result, bus.out_rd);
    end
    bus.out_ready = 1'b1;
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h22) begin
      failures++; $display("FAIL bp_second got=%b/%h exp=1/22", bus.out_valid, bus.out_result);
    end
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_back got=%b exp=1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_branch();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h7, 5'd9, 1'b1, 1'b1, 3'b100, 32'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checks += 3;
    if (bus.out_taken !== 1'b0) begin
      failures++; $display("FAIL blt_nt_taken got=%b exp=0", bus.out_taken);
    end
    if (bus.out_regwrite !== 1'b0) begin
      failures++; $display("FAIL blt_regwrite got=%b exp=0", bus.out_regwrite);
    end
    if (bus.out_target !== 32'h80) begin
      failures++; $display("FAIL blt_target got=%h exp=80", bus.out_target);
    end
    // Second branch is pushed while the first pops: head is replaced in one cycle.
    drive(1'b1, 32'h8, 5'd9, 1'b1, 1'b1, 3'b100, 32'h84, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_taken !== 1'b1 || bus.out_target !== 32'h84) begin
      failures++; $display("FAIL blt_t got=%b/%b/%h exp=1/1/84", bus.out_valid,
                           bus.out_taken, bus.out_target);
    end
    tick();
  endtask

  task automatic test_branch_conditions();
    logic [2:0] f3_t[8]  = '{3'b110, 3'b111, 3'b010, 3'b000, 3'b001, 3'b101, 3'b011, 3'b111};
    logic [3:0] fl_t[8]  = '{4'b0000, 4'b0000, 4'b1111, 4'b1000, 4'b1000, 4'b0000, 4'b1111, 4'b0001};
    logic       exp_t[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 5'(i), 1'b1, 1'b1, f3_t[i], 32'h100 + 32'(i),
            fl_t[i][3], fl_t[i][2], fl_t[i][1], fl_t[i][0]);
      tick();
      idle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_taken !== exp_t[i]) begin
        failures++; $display("FAIL cond_%0d f3=%b got=%b/%b exp=1/%b", i, f3_t[i],
                             bus.out_valid, bus.out_taken, exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA1, 5'd1, 1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hA2, 5'd2, 1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_prefull got=%b exp=0", bus.in_ready);
    end
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hA3, 5'd3, 1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    idle();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++; $display("FAIL flush_ghost_%0d got=%b/%h exp=0", i, bus.out_valid,
                             bus.out_result);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hB1, 5'd1, 1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB2, 5'd2, 1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL areset_prefull got=%b/%b exp=1/0", bus.out_valid, bus.in_ready);
    end
    #2 rst = 1'b0;
    #1;
    checks += 2;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL areset_valid got=%b exp=0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b1 || bus.out_result !== '0) begin
      failures++; $display("FAIL areset_state got=%b/%h exp=1/0", bus.in_ready, bus.out_result);
    end
    #2 rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL areset_after got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic            v, ordy, fl, br, rw, z, n, o, c, do_push, do_pop;
    logic [2:0]      f3;
    logic [XLEN-1:0] res, tgt;
    logic [RAW-1:0]  rd;
    logic [W-1:0]    got;
    exp_q.delete();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      br   = $urandom_range(0, 1);
      rw   = $urandom_range(0, 1);
      f3   = 3'($urandom_range(0, 7));
      z    = $urandom_range(0, 1);
      n    = $urandom_range(0, 1);
      o    = $urandom_range(0, 1);
      c    = $urandom_range(0, 1);
      res  = $urandom;
      tgt  = $urandom;
      rd   = 5'($urandom_range(0, 31));
      drive(v, res, rd, rw, br, f3, tgt, z, n, o, c);
      bus.out_ready = ordy;
      flush = fl;
      #3;
      checks += 2;
      if (bus.in_ready !== (exp_q.size() < 2)) begin
        failures++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready,
                             exp_q.size() < 2);
      end
      if (bus.out_valid !== (exp_q.size() > 0)) begin
        failures++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid,
                             exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        got = {bus.out_result, bus.out_rd, bus.out_regwrite, bus.out_taken, bus.out_target};
        checks++;
        if (got !== exp_q[0]) begin
          failures++; $display("FAIL rand_payload cyc=%0d got=%h exp=%h", cyc, got, exp_q[0]);
        end
      end
      do_push = v && (exp_q.size() < 2);
      do_pop  = ordy && (exp_q.size() > 0);
      @(posedge clk);
      if (fl) begin
        exp_q.delete();
      end else begin
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({res, rd, rw & ~br, ref_taken(br, f3, z, n, o, c), tgt});
      end
      #1;
    end
    flush = 1'b0;
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_backpressure();
    test_branch();
    test_branch_conditions();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
